// File: rtl/sfifo_pack_prefetch_if.sv
// Handshake bundle for sfifo_pack_prefetch: narrow write side, wide prefetched read side.
// The afull signal exists only when SFIFO_PACK_AFULL_EN is defined.
interface sfifo_pack_prefetch_if #(
  parameter int WR_DATA_WIDTH  = 16,
  parameter int RATIO          = 16,
  parameter int RD_DEPTH_WIDTH = 7
);
  localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO;

  logic                      wr_en;
  logic                      wr_vld;
  logic [WR_DATA_WIDTH-1:0]  wr_data;
  logic                      flush;
  logic                      rd_en;
  logic                      rd_vld;
  logic [RD_DATA_WIDTH-1:0]  rd_data;
  logic [RD_DEPTH_WIDTH:0]   rd_level;
  logic                      wr_ovf;
`ifdef SFIFO_PACK_AFULL_EN
  logic                      afull;

  modport master (
    output wr_en, wr_data, flush, rd_en,
    input  wr_vld, rd_vld, rd_data, rd_level, wr_ovf, afull
  );
  modport slave (
    input  wr_en, wr_data, flush, rd_en,
    output wr_vld, rd_vld, rd_data, rd_level, wr_ovf, afull
  );
`else
  modport master (
    output wr_en, wr_data, flush, rd_en,
    input  wr_vld, rd_vld, rd_data, rd_level, wr_ovf
  );
  modport slave (
    input  wr_en, wr_data, flush, rd_en,
    output wr_vld, rd_vld, rd_data, rd_level, wr_ovf
  );
`endif
endinterface

// File: rtl/sfifo_pack_prefetch.sv
// Width-packing FIFO: RATIO narrow words form one wide word, buffered in RAM, head prefetched.
// Define SFIFO_PACK_AFULL_EN to build the registered afull output (threshold AFULL_THRESH).
module sfifo_pack_prefetch #(
  parameter int WR_DATA_WIDTH  = 16,
  parameter int RATIO          = 16,
  parameter int RD_DEPTH_WIDTH = 7,
  parameter int LSB_FIRST      = 1,
  parameter int AFULL_THRESH   = 120
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sfifo_pack_prefetch_if.slave  fifo_io
);
  localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO;
  localparam int DEPTH         = 1 << RD_DEPTH_WIDTH;
  localparam int CNT_W         = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0]        LAST_SLOT = CNT_W'(RATIO - 1);
  localparam logic [RD_DEPTH_WIDTH:0] FULL_CNT  = (RD_DEPTH_WIDTH + 1)'(DEPTH);

  logic                       alive_q;
  logic [CNT_W-1:0]           pack_cnt_q, pack_cnt_d;
  logic [WR_DATA_WIDTH-1:0]   slot_q [RATIO];
  logic [WR_DATA_WIDTH-1:0]   slot_d [RATIO];
  logic                       flush_pend_q, flush_pend_d;
  logic [RD_DEPTH_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [RD_DEPTH_WIDTH:0]    ram_cnt_q, ram_cnt_d;
  logic                       rd_vld_q, rd_vld_d;
  logic [RD_DATA_WIDTH-1:0]   rd_data_q;
  logic [RD_DEPTH_WIDTH:0]    rd_level_q, rd_level_d;
  logic                       wr_ovf_q, wr_ovf_d;
  logic [RD_DATA_WIDTH-1:0]   ram_mem [DEPTH];
  logic [RD_DATA_WIDTH-1:0]   pack_word;

  logic ram_full, last_slot, wr_vld, accept, complete;
  logic flush_fresh, partial_push, push, load, pop;

  assign ram_full  = (ram_cnt_q == FULL_CNT);
  assign last_slot = (pack_cnt_q == LAST_SLOT);
  // alive_q keeps the write side closed until the first edge after reset release.
  assign wr_vld    = alive_q && !flush_pend_q && !(ram_full && last_slot);
  assign accept    = fifo_io.wr_en && wr_vld;
  assign complete  = accept && last_slot;

  // A flush closes a partial word that exists after this cycle's write; a write that
  // completes the word already pushes it, leaving nothing for the flush to do.
  assign flush_fresh  = fifo_io.flush && !flush_pend_q && !complete &&
                        (accept || (pack_cnt_q != '0));
  assign partial_push = (flush_fresh || flush_pend_q) && !ram_full;
  assign push         = complete || partial_push;
  assign pop          = fifo_io.rd_en && rd_vld_q;
  assign load         = (!rd_vld_q || fifo_io.rd_en) && (ram_cnt_q != '0);

  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d[pack_cnt_q] = fifo_io.wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam int LANE = (LSB_FIRST != 0) ? gi : (RATIO - 1 - gi);
      assign pack_word[LANE*WR_DATA_WIDTH +: WR_DATA_WIDTH] = slot_d[gi];
    end
  endgenerate

  always_comb begin
    pack_cnt_d   = pack_cnt_q;
    flush_pend_d = flush_pend_q;
    if (push) begin
      pack_cnt_d = '0;
    end else if (accept) begin
      pack_cnt_d = pack_cnt_q + CNT_W'(1);
    end
    if (flush_fresh && ram_full) begin
      flush_pend_d = 1'b1;
    end else if (partial_push) begin
      flush_pend_d = 1'b0;
    end
  end

  always_comb begin
    ram_cnt_d = ram_cnt_q + {{RD_DEPTH_WIDTH{1'b0}}, push} - {{RD_DEPTH_WIDTH{1'b0}}, load};
    rd_vld_d  = rd_vld_q;
    if (load) begin
      rd_vld_d = 1'b1;
    end else if (pop) begin
      rd_vld_d = 1'b0;
    end
    rd_level_d = ram_cnt_d + {{RD_DEPTH_WIDTH{1'b0}}, rd_vld_d};
    wr_ovf_d   = wr_ovf_q | (fifo_io.wr_en && !wr_vld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q      <= 1'b0;
      pack_cnt_q   <= '0;
      slot_q       <= '{default: '0};
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_cnt_q    <= '0;
      rd_vld_q     <= 1'b0;
      rd_level_q   <= '0;
      wr_ovf_q     <= 1'b0;
    end else begin
      alive_q      <= 1'b1;
      pack_cnt_q   <= pack_cnt_d;
      // Cleared after every push so a flushed partial word has zero-filled slots.
      if (push) begin
        slot_q <= '{default: '0};
      end else begin
        slot_q <= slot_d;
      end
      flush_pend_q <= flush_pend_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + RD_DEPTH_WIDTH'(1);
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + RD_DEPTH_WIDTH'(1);
      end
      ram_cnt_q  <= ram_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_level_q <= rd_level_d;
      wr_ovf_q   <= wr_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ram_mem[wr_ptr_q] <= pack_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (load) begin
      rd_data_q <= ram_mem[rd_ptr_q];
    end
  end

`ifdef SFIFO_PACK_AFULL_EN
  logic afull_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (int'(rd_level_d) >= AFULL_THRESH);
    end
  end

  assign fifo_io.afull = afull_q;
`endif

  assign fifo_io.wr_vld   = wr_vld;
  assign fifo_io.rd_vld   = rd_vld_q;
  assign fifo_io.rd_data  = rd_data_q;
  assign fifo_io.rd_level = rd_level_q;
  assign fifo_io.wr_ovf   = wr_ovf_q;
endmodule

// File: tb/tb_sfifo_pack_prefetch.sv
// Directed bench for sfifo_pack_prefetch: default 16x16 build plus an MSB-first 4x8 build.
module tb_sfifo_pack_prefetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfifo_pack_prefetch_if #(.WR_DATA_WIDTH(16), .RATIO(16), .RD_DEPTH_WIDTH(7)) fifo_a ();
  sfifo_pack_prefetch_if #(.WR_DATA_WIDTH(8), .RATIO(4), .RD_DEPTH_WIDTH(3)) fifo_b ();

  sfifo_pack_prefetch #(
    .WR_DATA_WIDTH(16), .RATIO(16), .RD_DEPTH_WIDTH(7), .LSB_FIRST(1), .AFULL_THRESH(120)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_io(fifo_a)
  );

  sfifo_pack_prefetch #(
    .WR_DATA_WIDTH(8), .RATIO(4), .RD_DEPTH_WIDTH(3), .LSB_FIRST(0), .AFULL_THRESH(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_io(fifo_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Wide word w of a sequential stream where narrow word n carries value n.
  function automatic logic [255:0] seq_word(input int w);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[j*16 +: 16] = 16'(w * 16 + j);
    return r;
  endfunction

  task automatic write_seq(input int count);
    for (int n = 0; n < count; n++) begin
      fifo_a.wr_en   = 1'b1;
      fifo_a.wr_data = 16'(n);
      step();
    end
    fifo_a.wr_en = 1'b0;
  endtask

  logic [255:0] exp_w;
  logic [7:0]   b_data [8];

  initial begin
    fifo_a.wr_en = 1'b0; fifo_a.wr_data = '0; fifo_a.flush = 1'b0; fifo_a.rd_en = 1'b0;
    fifo_b.wr_en = 1'b0; fifo_b.wr_data = '0; fifo_b.flush = 1'b0; fifo_b.rd_en = 1'b0;
    b_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // Reset state
    repeat (2) step();
    check("rst_wr_vld", fifo_a.wr_vld, 0);
    check("rst_rd_vld", fifo_a.rd_vld, 0);
    check("rst_rd_data", fifo_a.rd_data, 0);
    check("rst_rd_level", fifo_a.rd_level, 0);
    check("rst_wr_ovf", fifo_a.wr_ovf, 0);
    check("rst_b_level", fifo_b.rd_level, 0);
`ifdef SFIFO_PACK_AFULL_EN
    check("rst_afull", fifo_a.afull, 0);
`endif
    rst_n = 1'b1;
    step();
    check("rel_wr_vld", fifo_a.wr_vld, 1);

    // 1: sixteen words 1..16, latency of one cycle after the completing edge
    for (int i = 1; i <= 16; i++) begin
      fifo_a.wr_en = 1'b1; fifo_a.wr_data = 16'(i);
      step();
    end
    fifo_a.wr_en = 1'b0;
    check("t1_not_yet", fifo_a.rd_vld, 0);
    step();
    check("t1_rd_vld", fifo_a.rd_vld, 1);
    check("t1_lsb", fifo_a.rd_data[15:0], 16'h0001);
    check("t1_msb", fifo_a.rd_data[255:240], 16'h0010);
    check("t1_level", fifo_a.rd_level, 1);
    fifo_a.rd_en = 1'b1; step(); fifo_a.rd_en = 1'b0;
    check("t1_pop_vld", fifo_a.rd_vld, 0);
    check("t1_pop_level", fifo_a.rd_level, 0);

    // 2: partial word closed by flush, zero padded; second flush is a no-op
    fifo_a.wr_en = 1'b1;
    fifo_a.wr_data = 16'hA0A0; step();
    fifo_a.wr_data = 16'hB0B0; step();
    fifo_a.wr_data = 16'hC0C0; step();
    fifo_a.wr_en = 1'b0;
    fifo_a.flush = 1'b1; step(); fifo_a.flush = 1'b0;
    step();
    exp_w = '0;
    exp_w[47:0] = 48'hC0C0_B0B0_A0A0;
    check("t2_rd_vld", fifo_a.rd_vld, 1);
    check("t2_data", fifo_a.rd_data, exp_w);
    fifo_a.rd_en = 1'b1; step(); fifo_a.rd_en = 1'b0;
    fifo_a.flush = 1'b1; step(); fifo_a.flush = 1'b0;
    repeat (2) step();
    check("t2_flush2_vld", fifo_a.rd_vld, 0);
    check("t2_flush2_level", fifo_a.rd_level, 0);

    // 3: fill to capacity, overflow, then drain on consecutive cycles
    do_reset();
    write_seq(129 * 16);
    step();
    check("t3_level", fifo_a.rd_level, 129);
    check("t3_wr_vld_cnt0", fifo_a.wr_vld, 1);
`ifdef SFIFO_PACK_AFULL_EN
    check("t3_afull", fifo_a.afull, 1);
`endif
    for (int j = 0; j < 15; j++) begin
      fifo_a.wr_en = 1'b1; fifo_a.wr_data = 16'hFFFF;
      step();
    end
    fifo_a.wr_en = 1'b0;
    check("t3_wr_vld_cnt15", fifo_a.wr_vld, 0);
    check("t3_no_ovf", fifo_a.wr_ovf, 0);
    fifo_a.wr_en = 1'b1; fifo_a.wr_data = 16'hDEAD; step(); fifo_a.wr_en = 1'b0;
    check("t3_ovf", fifo_a.wr_ovf, 1);
    check("t3_level_kept", fifo_a.rd_level, 129);
    fifo_a.rd_en = 1'b1;
    for (int w = 0; w < 129; w++) begin
      check($sformatf("t3_vld_%0d", w), fifo_a.rd_vld, 1);
      check($sformatf("t3_word_%0d", w), fifo_a.rd_data, seq_word(w));
      step();
    end
    fifo_a.rd_en = 1'b0;
    check("t3_empty_vld", fifo_a.rd_vld, 0);
    check("t3_empty_level", fifo_a.rd_level, 0);
    check("t3_ovf_sticky", fifo_a.wr_ovf, 1);

    // 4: flush into a full RAM waits for a pop
    do_reset();
    write_seq(129 * 16);
    for (int j = 0; j < 5; j++) begin
      fifo_a.wr_en = 1'b1; fifo_a.wr_data = 16'(16'h5000 + j);
      step();
    end
    fifo_a.wr_en = 1'b0;
    check("t4_wr_vld_pre", fifo_a.wr_vld, 1);
    fifo_a.flush = 1'b1; step(); fifo_a.flush = 1'b0;
    check("t4_pend", fifo_a.wr_vld, 0);
    step();
    check("t4_pend_hold", fifo_a.wr_vld, 0);
    fifo_a.rd_en = 1'b1; step(); fifo_a.rd_en = 1'b0;
    check("t4_after_pop", fifo_a.wr_vld, 0);
    step();
    check("t4_pushed", fifo_a.wr_vld, 1);
    check("t4_level", fifo_a.rd_level, 129);
    fifo_a.rd_en = 1'b1;
    for (int w = 1; w < 129; w++) begin
      check($sformatf("t4_word_%0d", w), fifo_a.rd_data, seq_word(w));
      step();
    end
    exp_w = '0;
    for (int j = 0; j < 5; j++) exp_w[j*16 +: 16] = 16'(16'h5000 + j);
    check("t4_partial_vld", fifo_a.rd_vld, 1);
    check("t4_partial", fifo_a.rd_data, exp_w);
    step();
    fifo_a.rd_en = 1'b0;
    check("t4_empty", fifo_a.rd_vld, 0);

    // 5: asynchronous reset in the middle of a stream
    do_reset();
    fifo_a.rd_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      fifo_a.wr_en = 1'b1; fifo_a.wr_data = 16'(16'h7000 + i);
      step();
    end
    check("t5_pre_vld", fifo_a.rd_vld, 1);
    rst_n = 1'b0;
    fifo_a.wr_en = 1'b0;
    #2;
    check("t5_rst_vld", fifo_a.rd_vld, 0);
    check("t5_rst_data", fifo_a.rd_data, 0);
    check("t5_rst_level", fifo_a.rd_level, 0);
    check("t5_rst_wr_vld", fifo_a.wr_vld, 0);
    step();
    rst_n = 1'b1;
    step();
    check("t5_rel_wr_vld", fifo_a.wr_vld, 1);
    check("t5_rel_ovf", fifo_a.wr_ovf, 0);
    for (int j = 0; j < 16; j++) begin
      fifo_a.wr_en = 1'b1; fifo_a.wr_data = 16'(16'h9000 + j);
      step();
    end
    fifo_a.wr_en = 1'b0;
    for (int c = 0; c < 8 && !fifo_a.rd_vld; c++) step();
    exp_w = '0;
    for (int j = 0; j < 16; j++) exp_w[j*16 +: 16] = 16'(16'h9000 + j);
    check("t5_first_vld", fifo_a.rd_vld, 1);
    check("t5_first_word", fifo_a.rd_data, exp_w);
    step();
    fifo_a.rd_en = 1'b0;
    check("t5_drained", fifo_a.rd_level, 0);

    // 6: MSB-first packing on the narrow instance, level and afull
    for (int i = 0; i < 4; i++) begin
      fifo_b.wr_en = 1'b1; fifo_b.wr_data = b_data[i];
      step();
    end
    fifo_b.wr_en = 1'b0;
    step();
    check("t6_vld", fifo_b.rd_vld, 1);
    check("t6_data", fifo_b.rd_data, 32'h1122_3344);
    check("t6_level1", fifo_b.rd_level, 1);
`ifdef SFIFO_PACK_AFULL_EN
    check("t6_afull0", fifo_b.afull, 0);
`endif
    for (int i = 4; i < 8; i++) begin
      fifo_b.wr_en = 1'b1; fifo_b.wr_data = b_data[i];
      step();
    end
    fifo_b.wr_en = 1'b0;
    check("t6_level2", fifo_b.rd_level, 2);
    check("t6_head_hold", fifo_b.rd_data, 32'h1122_3344);
`ifdef SFIFO_PACK_AFULL_EN
    check("t6_afull1", fifo_b.afull, 1);
`endif
    fifo_b.rd_en = 1'b1; step(); fifo_b.rd_en = 1'b0;
    check("t6_second", fifo_b.rd_data, 32'h5566_7788);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
